tbox: RTL and testbench

Tic-tac-toe board engine for a two-player game. It holds the 3x3 board state and alternates turns starting with X. It accepts one move per request at a 1-based (row, col) coordinate and continuously reports the game result. It sits between the player-input logic, which drives the move requests, and the display or scoring logic, which reads the board and result outputs.

---
 rtl/tbox.sv | 116 +++++++++++
 tb/tb_tbox.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tbox.sv
// rtl/tbox.sv - tic-tac-toe board engine: 3x3 board, alternating turns from X, combinational result
// Optional define TBOX_SET_EDGE_EN: accept at most one move per rising edge of set.
module tbox (
    input  logic       clk,
    input  logic       reset,
    input  logic       set,
    input  logic [1:0] row,
    input  logic [1:0] col,
    output logic [8:0] valid,
    output logic [8:0] symbol,
    output logic [1:0] game_state
);

    // Rows, columns, then the two diagonals, as cell masks (bit 0 = top-left)
    localparam logic [8:0] line_mask [8] = '{
        9'h007, 9'h038, 9'h1c0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    logic [8:0] valid_q  = 9'h000;
    logic [8:0] symbol_q = 9'h000;
    logic       turn_q   = 1'b1;

    logic [2:0] row_oh;
    logic [2:0] col_oh;
    logic [8:0] cell_sel;
    logic [8:0] x_cells;
    logic [8:0] o_cells;
    logic       x_win;
    logic       o_win;
    logic       set_ok;
    logic       accept;

    // Out-of-range coordinates decode to an empty one-hot, which rejects the move
    always_comb begin
        row_oh = 3'b000;
        col_oh = 3'b000;
        case (row)
            2'd1:    row_oh = 3'b001;
            2'd2:    row_oh = 3'b010;
            2'd3:    row_oh = 3'b100;
            default: row_oh = 3'b000;
        endcase
        case (col)
            2'd1:    col_oh = 3'b001;
            2'd2:    col_oh = 3'b010;
            2'd3:    col_oh = 3'b100;
            default: col_oh = 3'b000;
        endcase
    end

    always_comb begin
        cell_sel = 9'h000;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                cell_sel[r*3+c] = row_oh[r] & col_oh[c];
            end
        end
    end

    assign x_cells = valid_q & symbol_q;
    assign o_cells = valid_q & ~symbol_q;

    always_comb begin
        x_win = 1'b0;
        o_win = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((x_cells & line_mask[i]) == line_mask[i]) x_win = 1'b1;
            if ((o_cells & line_mask[i]) == line_mask[i]) o_win = 1'b1;
        end
    end

    always_comb begin
        game_state = 2'b00;
        if (x_win)
            game_state = 2'b01;
        else if (o_win)
            game_state = 2'b10;
        else if (&valid_q)
            game_state = 2'b11;
    end

`ifdef TBOX_SET_EDGE_EN
    logic set_q = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            set_q <= 1'b0;
        else
            set_q <= set;
    end

    assign set_ok = set & ~set_q;
`else
    assign set_ok = set;
`endif

    assign accept = set_ok && (|cell_sel) && !(|(cell_sel & valid_q)) && (game_state == 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 9'h000;
            symbol_q <= 9'h000;
            turn_q   <= 1'b1;
        end else if (accept) begin
            valid_q  <= valid_q | cell_sel;
            symbol_q <= turn_q ? (symbol_q | cell_sel) : (symbol_q & ~cell_sel);
            turn_q   <= ~turn_q;
        end
    end

    assign valid  = valid_q;
    assign symbol = symbol_q & valid_q;

endmodule

// File: tb/tb_tbox.sv
// tb/tb_tbox.sv - scoreboard bench for tbox against a board-array reference model
module tb_tbox;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       set = 1'b0;
    logic [1:0] row = 2'd0;
    logic [1:0] col = 2'd0;
    logic [8:0] valid;
    logic [8:0] symbol;
    logic [1:0] game_state;

    tbox dut (
        .clk        (clk),
        .reset      (reset),
        .set        (set),
        .row        (row),
        .col        (col),
        .valid      (valid),
        .symbol     (symbol),
        .game_state (game_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] v;
        logic [8:0] s;
        logic [1:0] g;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: board[r][c] is 0 empty, 1 X, 2 O
    int board [3][3];
    int m_turn = 1;
    bit m_prev = 1'b0;

    function automatic int m_result();
        int w;
        bit full;
        w = 0;
        for (int i = 0; i < 3; i++) begin
            if (board[i][0] != 0 && board[i][0] == board[i][1] && board[i][1] == board[i][2]) w = board[i][0];
            if (board[0][i] != 0 && board[0][i] == board[1][i] && board[1][i] == board[2][i]) w = board[0][i];
        end
        if (board[1][1] != 0 && board[0][0] == board[1][1] && board[1][1] == board[2][2]) w = board[1][1];
        if (board[1][1] != 0 && board[0][2] == board[1][1] && board[1][1] == board[2][0]) w = board[1][1];
        if (w != 0) return w;
        full = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (board[r][c] == 0) full = 1'b0;
        return full ? 3 : 0;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                board[r][c] = 0;
        m_turn = 1;
        m_prev = 1'b0;
    endtask

    task automatic m_edge(bit s, int r, int c);
        bit ok;
        ok = s && r >= 1 && r <= 3 && c >= 1 && c <= 3 && m_result() == 0;
`ifdef TBOX_SET_EDGE_EN
        ok = ok && !m_prev;
        m_prev = s;
`endif
        if (ok) begin
            if (board[r-1][c-1] == 0) begin
                board[r-1][c-1] = m_turn;
                m_turn = (m_turn == 1) ? 2 : 1;
            end
        end
    endtask

    task automatic push(string tag);
        exp_t e;
        e.v = '0;
        e.s = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                e.v[r*3+c] = (board[r][c] != 0);
                e.s[r*3+c] = (board[r][c] == 1);
            end
        end
        e.g   = 2'(m_result());
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic check(string name, logic [8:0] got, logic [8:0] want);
        n_checks++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s got %h want %h", name, got, want);
    endtask

    // Monitor: outputs are stable at the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, " valid"}, valid, e.v);
            check({e.tag, " symbol"}, symbol, e.s);
            check({e.tag, " game_state"}, {7'd0, game_state}, {7'd0, e.g});
        end
    end

    task automatic do_move(bit s, int r, int c, string tag);
        set = s;
        row = 2'(r);
        col = 2'(c);
        @(posedge clk);
        m_edge(s, r, c);
        push(tag);
        @(negedge clk);
        #1;
    endtask

    task automatic play(int r, int c, string tag);
        do_move(1'b1, r, c, tag);
        do_move(1'b0, r, c, {tag, " idle"});
    endtask

    // Reset asserted between edges, then held across an edge with a move pending
    task automatic async_reset(bit s, string tag);
        set = 1'b0;
        @(posedge clk);
        m_edge(1'b0, 0, 0);
        #2;
        reset = 1'b1;
        m_reset();
        push({tag, " async"});
        @(negedge clk);
        #1;
        set = s;
        row = 2'(1 + ($urandom % 3));
        col = 2'(1 + ($urandom % 3));
        @(posedge clk);
        push({tag, " hold"});
        @(negedge clk);
        #1;
        reset = 1'b0;
        set   = 1'b0;
    endtask

    initial begin
        int guard;
        m_reset();
        push("powerup");
        @(negedge clk);
        #1;

        play(1,1,"ow1"); play(2,2,"ow2"); play(1,3,"ow3");
        play(1,2,"ow4"); play(3,3,"ow5"); play(3,2,"ow6");
        play(2,1,"ow_frozen");

        async_reset(1'b1, "r1");
        play(1,1,"xr1"); play(2,2,"xr2"); play(1,3,"xr3");
        play(3,2,"xr4"); play(1,2,"xr5"); play(3,3,"xr_frozen");

        async_reset(1'b0, "r2");
        play(1,1,"rep1"); play(1,1,"rep2"); play(2,2,"rep_o");
        do_move(1'b1, 3, 3, "hold1");
        do_move(1'b1, 3, 3, "hold2");
        do_move(1'b1, 3, 1, "hold3");
        do_move(1'b0, 0, 0, "hold_idle");
        play(0,2,"row0"); play(2,0,"col0");

        async_reset(1'b1, "r3");
        play(1,1,"xc1"); play(1,2,"xc2"); play(2,1,"xc3");
        play(2,2,"xc4"); play(3,1,"xc5");

        async_reset(1'b0, "r4");
        play(1,1,"d1"); play(1,2,"d2"); play(1,3,"d3");
        play(2,2,"d4"); play(2,1,"d5"); play(2,3,"d6");
        play(3,2,"d7"); play(3,1,"d8"); play(3,3,"d9");
        play(1,1,"d_frozen");

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 2 || (m_result() != 0 && $urandom_range(0, 99) < 20))
                async_reset($urandom_range(0, 1) == 1, "rnd_rst");
            else
                do_move($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3), "rnd");
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL drain pending %0d want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
